// File: rtl/fetch_queue.sv
// fetch_queue
// -----------
// Instruction fetch sequencer. Owns the fetch PC, addresses a combinational
// instruction memory, and buffers fetched {pc, instr} pairs in a small FIFO
// that feeds decode over a valid/ready handshake. A redirect flushes the FIFO
// and restarts fetch at the target. Halt stops new fetches while the FIFO
// keeps draining.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   imem_addr      word address into instruction memory (fetch_pc[ADDR_WIDTH+1:2])
//   imem_rd        instruction word returned combinationally for imem_addr
//   halt           block new fetches
//   redirect_valid flush FIFO and restart at redirect_pc
//   redirect_pc    redirect target (bits [1:0] ignored)
//   out_valid      head entry is valid
//   out_ready      decode accepts the head this cycle
//   out_instr      head instruction word
//   out_pc         PC of the head instruction
//   count          FIFO occupancy
module fetch_queue #(
    parameter int              XLEN       = 32,
    parameter int              ADDR_WIDTH = 8,
    parameter int              DEPTH      = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [ADDR_WIDTH-1:0]    imem_addr,
    input  logic [31:0]              imem_rd,
    input  logic                     halt,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic             push;
    logic             pop;
    logic [XLEN-1:0]  redirect_target;

    // Masking (rather than slicing) keeps every redirect_pc bit in use.
    assign redirect_target = redirect_pc & ~XLEN'(3);

    assign out_valid = (count_reg != '0);
    assign pop       = out_valid & out_ready & ~redirect_valid;
    // A full FIFO may still accept a push when the head leaves the same cycle.
    assign push      = ~halt & ~redirect_valid &
                       ((count_reg < CNT_W'(DEPTH)) | pop);

    assign imem_addr = fetch_pc_reg[ADDR_WIDTH+1:2];
    assign out_instr = instr_mem[rd_ptr_reg];
    assign out_pc    = pc_mem[rd_ptr_reg];
    assign count     = count_reg;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        if (redirect_valid) begin
            fetch_pc_next = redirect_target;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (push) begin
                fetch_pc_next = fetch_pc_reg + XLEN'(4);
                wr_ptr_next   = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc_reg <= RESET_PC;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    pc_mem[gi]    <= '0;
                    instr_mem[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    pc_mem[gi]    <= fetch_pc_reg;
                    instr_mem[gi] <= imem_rd;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. Instruction memory model: imem[k] = k + 'h100.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rd = 32'h100 + {24'h0, imem_addr};

    fetch_queue dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .count          (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock edge, then settle before checks and new drives.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_pc", out_pc, 0);
        check("rst_instr", out_instr, 0);
        check("rst_addr", imem_addr, 0);

        // Cycle 0: reset released, nothing buffered yet.
        reset_n = 1'b1;
        check("c0_valid", out_valid, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            check("stream_valid", out_valid, 1);
            check("stream_pc", out_pc, 64'(4 * k));
            check("stream_instr", out_instr, 64'(32'h100 + k));
            step();
        end

        // Restart at 0 with backpressure applied from the redirect cycle on.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        step();
        redirect_valid = 1'b0;
        check("bp_flush_count", count, 0);
        step();
        check("bp_count1", count, 1);
        step();
        check("bp_count2", count, 2);
        check("bp_addr_hold", imem_addr, 2);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_sat_count", count, 2);
            check("bp_sat_addr", imem_addr, 2);
            check("bp_head_pc", out_pc, 0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_rel_pc", out_pc, 64'(4 * k));
            check("bp_rel_instr", out_instr, 64'(32'h100 + k));
            check("bp_full_pushpop_count", count, 2);
            step();
        end

        // Redirect to 0x40 with a full FIFO.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("rd40_valid", out_valid, 0);
        check("rd40_count", count, 0);
        check("rd40_addr", imem_addr, 8'h10);
        step();
        check("rd40_tgt_valid", out_valid, 1);
        check("rd40_tgt_pc", out_pc, 32'h40);
        check("rd40_tgt_instr", out_instr, 32'h110);

        // Refill, then redirect to unaligned 0x43.
        out_ready = 1'b0;
        step();
        check("rd43_pre_count", count, 2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        step();
        redirect_valid = 1'b0;
        check("rd43_valid", out_valid, 0);
        check("rd43_count", count, 0);
        step();
        check("rd43_tgt_pc", out_pc, 32'h40);
        check("rd43_tgt_instr", out_instr, 32'h110);

        // Halt for 4 cycles while draining.
        halt      = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("halt_valid", out_valid, 0);
            check("halt_count", count, 0);
            check("halt_addr", imem_addr, 8'h11);
        end
        halt = 1'b0;
        step();
        check("resume_pc", out_pc, 32'h44);
        check("resume_instr", out_instr, 32'h111);

        // Address wrap at the 256-word boundary.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FC;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr255", imem_addr, 8'hFF);
        step();
        check("wrap_pc3fc", out_pc, 32'h3FC);
        check("wrap_instr3fc", out_instr, 32'h1FF);
        check("wrap_addr0", imem_addr, 0);
        step();
        check("wrap_pc400", out_pc, 32'h400);
        check("wrap_instr400", out_instr, 32'h100);

        // PC wrap at 2^32.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check("pcwrap_top", out_pc, 32'hFFFF_FFFC);
        check("pcwrap_top_instr", out_instr, 32'h1FF);
        step();
        check("pcwrap_zero", out_pc, 0);
        check("pcwrap_zero_instr", out_instr, 32'h100);

        // Reset mid-stream with a full FIFO; reset beats a concurrent redirect.
        out_ready = 1'b0;
        step();
        check("mr_full", count, 2);
        reset_n        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        check("mr_valid", out_valid, 0);
        check("mr_count", count, 0);
        check("mr_pc", out_pc, 0);
        check("mr_instr", out_instr, 0);
        check("mr_addr", imem_addr, 0);
        reset_n        = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step();
        check("mr_restart_valid", out_valid, 1);
        check("mr_restart_pc", out_pc, 0);
        check("mr_restart_instr", out_instr, 32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
